// File: rtl/ref_fill_axi_rd_master_pkg.sv
// ref_fill_axi_rd_master_pkg: AXI constants, default widths and clog2 for the reference-fill read master
package ref_fill_axi_rd_master_pkg;
    typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} axi_burst_e;
    typedef enum logic [1:0] {RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11} axi_resp_e;
    localparam int DEF_ADD_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_ADD_ID_WIDTH = 4;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_BURST_SIZE = 3;
    localparam int DEF_BURST_TYPE = 2;
    localparam int DEF_FILL_BEATS = 4;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_TAG_WIDTH = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ref_fill_tag_fifo.sv
// ref_fill_tag_fifo: synchronous FIFO holding {id, tag} of each burst in flight
module ref_fill_tag_fifo
    import ref_fill_axi_rd_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ref_fill_axi_rd_master.sv
// ref_fill_axi_rd_master: turns line-fill requests into INCR bursts and streams tagged R beats to the fill port
module ref_fill_axi_rd_master
    import ref_fill_axi_rd_master_pkg::*;
#(
    parameter int ADD_WIDTH = DEF_ADD_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_ID_WIDTH = DEF_ADD_ID_WIDTH,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int BURST_SIZE = DEF_BURST_SIZE,
    parameter int BURST_TYPE = DEF_BURST_TYPE,
    parameter int FILL_BEATS = DEF_FILL_BEATS,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADD_WIDTH-1:0]                 req_addr,
    input  logic [TAG_WIDTH-1:0]                 req_tag,
    output logic [ADD_ID_WIDTH-1:0]              arid,
    output logic [ADD_WIDTH-1:0]                 araddr,
    output logic [BURST_LEN-1:0]                 arlen,
    output logic [BURST_SIZE-1:0]                arsize,
    output logic [BURST_TYPE-1:0]                arburst,
    output logic [1:0]                           arlock,
    output logic [3:0]                           arcache,
    output logic [2:0]                           arprot,
    output logic                                 arvalid,
    input  logic                                 arready,
    input  logic [ADD_ID_WIDTH-1:0]              rid,
    input  logic [DATA_WIDTH-1:0]                rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 rlast,
    input  logic                                 rvalid,
    output logic                                 rready,
    output logic                                 fill_valid,
    input  logic                                 fill_ready,
    output logic [DATA_WIDTH-1:0]                fill_data,
    output logic [TAG_WIDTH-1:0]                 fill_tag,
    output logic [clog2(FILL_BEATS):0]           fill_beat,
    output logic                                 fill_last,
    output logic                                 err,
    output logic [clog2(MAX_OUTSTANDING):0]      outstanding
);
    localparam int LINE_LOG = clog2(FILL_BEATS * DATA_WIDTH / 8);
    localparam int BW = clog2(FILL_BEATS) + 1;
    localparam int OW = clog2(MAX_OUTSTANDING) + 1;
    localparam int FW = ADD_ID_WIDTH + TAG_WIDTH;
    logic [BW-1:0] beat_cnt;
    logic [ADD_ID_WIDTH-1:0] id_cnt;
    logic [FW-1:0] head;
    logic fifo_empty, fifo_full;
    logic accept, r_fire, cnt_last, bad, dec, pop;
    assign arlen = BURST_LEN'(FILL_BEATS - 1);
    assign arsize = BURST_SIZE'(clog2(DATA_WIDTH / 8));
    assign arburst = BURST_TYPE'(BURST_INCR);
    assign arlock = '0;
    assign arcache = '0;
    assign arprot = '0;
    // The full term only matters after an early rlast has freed a slot before its tag pops
    assign req_ready = !arvalid && (outstanding < OW'(MAX_OUTSTANDING)) && !fifo_full;
    assign accept = req_valid && req_ready;
    assign rready = !fill_valid || fill_ready;
    assign r_fire = rvalid && rready;
    assign cnt_last = beat_cnt == BW'(FILL_BEATS - 1);
    assign pop = r_fire && !fifo_empty && cnt_last;
    assign bad = fifo_empty || rresp != RESP_OKAY || rid != head[FW-1:TAG_WIDTH] || rlast != cnt_last;
    assign dec = r_fire && rlast && outstanding != '0;
    ref_fill_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(FW)) u_tag_fifo (
        .clk(clk),
        .reset(reset),
        .push(accept),
        .push_data({id_cnt, req_tag}),
        .pop(pop),
        .head(head),
        .empty(fifo_empty),
        .full(fifo_full)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arvalid <= 1'b0;
            araddr <= '0;
            arid <= '0;
            id_cnt <= '0;
            outstanding <= '0;
            beat_cnt <= '0;
            fill_valid <= 1'b0;
            fill_data <= '0;
            fill_tag <= '0;
            fill_beat <= '0;
            fill_last <= 1'b0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                arvalid <= 1'b1;
                araddr <= (req_addr >> LINE_LOG) << LINE_LOG;
                arid <= id_cnt;
                id_cnt <= id_cnt + ADD_ID_WIDTH'(1);
            end else if (arready) begin
                arvalid <= 1'b0;
            end
            outstanding <= outstanding + OW'(accept) - OW'(dec);
            // Beat bookkeeping follows the expected count, never rlast
            if (r_fire && !fifo_empty) begin
                fill_valid <= 1'b1;
                fill_data <= rdata;
                fill_tag <= head[TAG_WIDTH-1:0];
                fill_beat <= beat_cnt;
                fill_last <= cnt_last;
                beat_cnt <= cnt_last ? '0 : beat_cnt + BW'(1);
            end else if (fill_ready) begin
                fill_valid <= 1'b0;
            end
            if (r_fire && bad) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ref_fill_axi_rd_master.sv
// tb_ref_fill_axi_rd_master: scoreboard bench with an AXI read-slave model for ref_fill_axi_rd_master
module tb_ref_fill_axi_rd_master;
    localparam int AW = 32, DW = 512, IW = 4, TW = 8;
    typedef struct {logic [IW-1:0] id; logic [AW-1:0] a; logic [TW-1:0] t;} req_t;
    typedef struct {logic [DW-1:0] d; logic [TW-1:0] t; logic [2:0] b; logic l;} exp_t;
    logic clk = 0, reset = 1;
    logic req_valid = 0, req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [TW-1:0] req_tag = '0;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [3:0] arlen, arcache;
    logic [2:0] arsize, arprot;
    logic [1:0] arburst, arlock;
    logic arvalid, arready = 0;
    logic [IW-1:0] rid = '0;
    logic [DW-1:0] rdata = '0;
    logic [1:0] rresp = '0;
    logic rlast = 0, rvalid = 0, rready;
    logic fill_valid, fill_ready = 1, fill_last, err;
    logic [DW-1:0] fill_data;
    logic [TW-1:0] fill_tag;
    logic [2:0] fill_beat, outstanding, sim_prev;
    req_t req_q[$], sb_q[$];
    exp_t exp_q[$];
    logic [IW-1:0] id_exp = '0;
    int n_chk = 0, n_fail = 0, out_m = 0, sbeat = 0, ar_wait = 0, ar_delay = 0, err_inj = 0, r_cnt = 0, sim_cnt = 0;
    logic err_m = 0, r_fire_d = 0, presenting = 0, r_hold = 0, fill_toggle = 0, sim_chk = 0;

    ref_fill_axi_rd_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_tag(req_tag), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data), .fill_tag(fill_tag),
        .fill_beat(fill_beat), .fill_last(fill_last), .err(err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, slave drive just after the rising edge
    initial forever begin
        @(negedge clk);
        if (reset) begin
            req_q.delete(); sb_q.delete(); exp_q.delete();
            id_exp = '0; out_m = 0; err_m = 0; r_fire_d = 0; sim_chk = 0;
        end else begin
            exp_t e;
            req_t q;
            check("outstanding", DW'(outstanding), DW'(out_m));
            check("err", DW'(err), DW'(err_m));
            if (fill_valid && !fill_ready) check("rready_bp", DW'(rready), DW'(0));
            if (sim_chk) begin
                check("simul_out", DW'(outstanding), DW'(sim_prev));
                sim_chk = 0;
            end
            if (fill_valid && fill_ready) begin
                if (exp_q.size() == 0) check("fill_unexpected", DW'(1), DW'(0));
                else begin
                    e = exp_q.pop_front();
                    check("fill_data", fill_data, e.d);
                    check("fill_tag", DW'(fill_tag), DW'(e.t));
                    check("fill_beat", DW'(fill_beat), DW'(e.b));
                    check("fill_last", DW'(fill_last), DW'(e.l));
                end
            end
            if (arvalid && arready) begin
                if (req_q.size() == 0) check("ar_unexpected", DW'(1), DW'(0));
                else begin
                    q = req_q.pop_front();
                    check("araddr", DW'(araddr), DW'(q.a));
                    check("arid", DW'(arid), DW'(q.id));
                    check("arlen", DW'(arlen), DW'(3));
                    check("arsize", DW'(arsize), DW'(6));
                    check("arburst", DW'(arburst), DW'(1));
                    check("ar_misc", DW'({arlock, arcache, arprot}), DW'(0));
                    sb_q.push_back(q);
                end
            end
            r_fire_d = rvalid && rready;
            if (r_fire_d) begin
                r_cnt++;
                if (sb_q.size() == 0) err_m = 1;
                else begin
                    if (rresp != 2'b00 || rid != sb_q[0].id || rlast != (sbeat == 3)) err_m = 1;
                    exp_q.push_back('{rdata, sb_q[0].t, 3'(sbeat), sbeat == 3});
                end
                if (rlast && out_m > 0) out_m--;
            end
            if (req_valid && req_ready) begin
                if (r_fire_d && rlast) begin
                    sim_chk = 1; sim_prev = outstanding; sim_cnt++;
                end
                req_q.push_back('{id_exp, req_addr & 32'hFFFF_FF00, req_tag});
                id_exp = id_exp + IW'(1);
                out_m++;
            end
        end
        @(posedge clk);
        #1;
        if (reset) begin
            rvalid = 0; presenting = 0; sbeat = 0; arready = 0; ar_wait = 0; fill_ready = 1;
        end else begin
            if (arvalid) begin
                arready = ar_wait >= ar_delay;
                ar_wait++;
            end else begin
                arready = 0; ar_wait = 0;
            end
            if (r_fire_d) begin
                presenting = 0; r_fire_d = 0;
                if (sbeat == 3) begin sbeat = 0; sb_q.delete(0); end
                else sbeat++;
            end
            if (!presenting && !r_hold && sb_q.size() > 0) begin
                for (int k = 0; k < DW / 32; k++) rdata[k*32 +: 32] = $urandom();
                rid = sb_q[0].id ^ IW'(err_inj == 2 && sbeat == 0);
                rresp = (err_inj == 1 && sbeat == 1) ? 2'b10 : 2'b00;
                rlast = (err_inj == 3) ? (sbeat == 2) : (sbeat == 3);
                rvalid = 1; presenting = 1;
            end else if (!presenting) rvalid = 0;
            fill_ready = fill_toggle ? !fill_ready : 1'b1;
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input logic [TW-1:0] t);
        int i;
        @(posedge clk);
        #1;
        req_addr = a; req_tag = t; req_valid = 1;
        i = 0;
        @(negedge clk);
        while (!req_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) check("req_timeout", DW'(0), DW'(1));
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = exp_q.size() == 0 && sb_q.size() == 0 && req_q.size() == 0 && !fill_valid && !arvalid && outstanding == 0;
        end
        if (!done) check("idle_timeout", DW'(0), DW'(1));
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic wait_ar_done();
        int i;
        i = 0;
        while (arvalid && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (arvalid) check("ar_timeout", DW'(0), DW'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bit hit;
        int base;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check("rst_arvalid", DW'(arvalid), DW'(0));
        check("rst_fill_valid", DW'(fill_valid), DW'(0));
        check("rst_err", DW'(err), DW'(0));
        check("rst_outstanding", DW'(outstanding), DW'(0));
        check("rst_req_ready", DW'(req_ready), DW'(1));
        check("rst_rready", DW'(rready), DW'(1));
        // Single fill
        do_req(32'h0000_1234, 8'h5A);
        wait_idle();
        // Throughput: five requests, slow first AR, R held until the limit is reached
        r_hold = 1; ar_delay = 3;
        do_req(32'h0000_0103, 8'h10);
        wait_ar_done();
        ar_delay = 0;
        for (int i = 1; i < 4; i++) do_req(AW'(32'h100 * (i + 1) + 3), TW'(8'h10 + i));
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0503; req_tag = 8'h14; req_valid = 1;
        repeat (4) begin
            @(negedge clk);
            check("full_req_ready", DW'(req_ready), DW'(0));
        end
        check("full_outstanding", DW'(outstanding), DW'(4));
        r_hold = 0;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = req_ready;
        end
        check("recover_ready", DW'(hit), DW'(1));
        check("recover_outstanding", DW'(outstanding), DW'(3));
        @(posedge clk);
        #1 req_valid = 0;
        wait_idle();
        // Back-pressure
        fill_toggle = 1;
        do_req(32'h0000_2000, 8'hA1);
        do_req(32'h0000_2100, 8'hA2);
        wait_idle();
        fill_toggle = 0;
        // Request accepted on the same edge as an rlast beat
        r_hold = 1;
        do_req(32'h0000_3000, 8'hC1);
        wait_ar_done();
        r_hold = 0;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = rvalid && rlast && rready;
        end
        check("simul_found", DW'(hit), DW'(1));
        req_addr = 32'h0000_3100; req_tag = 8'hC2; req_valid = 1;
        @(negedge clk);
        check("simul_ready", DW'(req_ready), DW'(1));
        @(posedge clk);
        #1 req_valid = 0;
        wait_idle();
        check("simul_seen", DW'(sim_cnt), DW'(1));
        // Error cases: bad rresp, bad rid, early rlast
        for (int m = 1; m <= 3; m++) begin
            reset_dut();
            err_inj = m;
            do_req(AW'(32'h0000_6000 + m * 32'h100), TW'(8'hE0 + m));
            wait_idle();
            check("err_sticky", DW'(err), DW'(1));
            err_inj = 0;
        end
        // Reset in the middle of a burst
        base = r_cnt;
        do_req(32'h0000_8040, 8'h33);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            hit = r_cnt >= base + 2;
        end
        check("mid_beats", DW'(hit), DW'(1));
        @(posedge clk);
        #3 reset = 1;
        #1;
        check("mid_arvalid", DW'(arvalid), DW'(0));
        check("mid_fill_valid", DW'(fill_valid), DW'(0));
        check("mid_err", DW'(err), DW'(0));
        check("mid_outstanding", DW'(outstanding), DW'(0));
        check("mid_araddr", DW'(araddr), DW'(0));
        check("mid_arid", DW'(arid), DW'(0));
        check("mid_fill_data", fill_data, DW'(0));
        check("mid_fill_tag", DW'(fill_tag), DW'(0));
        repeat (2) @(posedge clk);
        #1 reset = 0;
        do_req(32'h0000_4440, 8'h77);
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
